// File: rtl/gnn_pkg.sv
// Shared types and defaults for the GNN vertex datapath weight streaming logic.
package gnn_pkg;

  // Strobes sent to the feature bank: start, end and layer change of a stream.
  typedef struct packed {
    logic sos;
    logic eos;
    logic change;
  } weight_bank_ctrl_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WORK = 1'b1
  } weight_state_t;

  localparam int DEF_LANES      = 4;
  localparam int DEF_FV_SIZE    = 16;
  localparam int DEF_MAX_FV     = 16;
  localparam int DEF_MAX_LAYERS = 2;
  localparam int DEF_BANK_DLY   = 3;

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_stream_ctrl_if.sv
// Bus between the reservation station / host side and the weight stream controller.
interface weight_stream_ctrl_if #(
  parameter int LANES      = gnn_pkg::DEF_LANES,
  parameter int FV_SIZE    = gnn_pkg::DEF_FV_SIZE,
  parameter int MAX_FV     = gnn_pkg::DEF_MAX_FV,
  parameter int MAX_LAYERS = gnn_pkg::DEF_MAX_LAYERS
);
  localparam int LW = gnn_pkg::idx_w(MAX_LAYERS);
  localparam int FW = gnn_pkg::idx_w(MAX_FV);
  localparam int CW = $clog2(MAX_FV) + 1;

  // Buffer write port
  logic                     wr_en;
  logic [LW-1:0]            wr_layer;
  logic [FW-1:0]            wr_idx;
  logic [FV_SIZE-1:0]       wr_data;
  // Stream request and configuration
  logic [LW-1:0]            num_layer;
  logic [CW-1:0]            num_fv;
  logic                     fire;
  logic                     stall;
  // Weight stream towards the vertex PEs
  logic [LANES*FV_SIZE-1:0] weight_data;
  logic [LANES-1:0]         weight_valid;
  logic [CW-1:0]            cur_fv_num;
  logic [LW-1:0]            cur_layer;
  // Feature bank strobes and status
  logic                     bank_sos;
  logic                     bank_change;
  logic                     bank_eos;
  logic                     rs_idle;

  modport master (
    output wr_en, wr_layer, wr_idx, wr_data, num_layer, num_fv, fire, stall,
    input  weight_data, weight_valid, cur_fv_num, cur_layer,
    input  bank_sos, bank_change, bank_eos, rs_idle
  );

  modport slave (
    input  wr_en, wr_layer, wr_idx, wr_data, num_layer, num_fv, fire, stall,
    output weight_data, weight_valid, cur_fv_num, cur_layer,
    output bank_sos, bank_change, bank_eos, rs_idle
  );

endinterface

// File: rtl/sig_delay_pipe.sv
// Fixed-latency shift register for the feature bank strobes.
module sig_delay_pipe #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  // Shift strobes one stage per cycle; reset flushes anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/weight_stream_ctrl.sv
// Streams LANES weights per cycle from a loadable buffer over all chunks of
// all layers, with delayed start/change/end strobes for the feature bank.
module weight_stream_ctrl
  import gnn_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int FV_SIZE    = DEF_FV_SIZE,
  parameter int MAX_FV     = DEF_MAX_FV,
  parameter int MAX_LAYERS = DEF_MAX_LAYERS,
  parameter int BANK_DLY   = DEF_BANK_DLY
) (
  input  logic clk,
  input  logic reset,
  weight_stream_ctrl_if.slave bus
);

  localparam int LW = idx_w(MAX_LAYERS);
  localparam int FW = idx_w(MAX_FV);
  localparam int CW = $clog2(MAX_FV) + 1;
  localparam int BW = $bits(weight_bank_ctrl_t);

  weight_state_t            state_q, state_d;
  logic [CW-1:0]            fv_q, fv_d, num_fv_q, num_fv_d;
  logic [LW-1:0]            layer_q, layer_d, num_layer_q, num_layer_d;
  logic [FV_SIZE-1:0]       wbuf_q [MAX_LAYERS][MAX_FV];
  logic [LANES*FV_SIZE-1:0] lane_data, wdata_q;
  logic [LANES-1:0]         lane_vld, wvalid_q;
  logic [CW-1:0]            cur_fv_q;
  logic [LW-1:0]            cur_layer_q;
  logic                     rs_idle_q;
  logic                     accept, emit, last_chunk, last_layer;
  logic [CW-1:0]            fire_fv;
  logic [LW-1:0]            fire_layer;
  weight_bank_ctrl_t        strobe_gen, strobe_out;
  logic [BW-1:0]            strobe_out_vec;

  // Oversized lengths saturate so the fv counter can never run past the buffer.
  assign fire_fv = (bus.num_fv > CW'(MAX_FV)) ? CW'(MAX_FV) : bus.num_fv;

  generate
    if ((2**LW) > MAX_LAYERS) begin : g_layer_clamp
      assign fire_layer = (bus.num_layer > LW'(MAX_LAYERS-1)) ? LW'(MAX_LAYERS-1) : bus.num_layer;
    end else begin : g_layer_pass
      assign fire_layer = bus.num_layer;
    end
  endgenerate

  assign last_chunk = ({1'b0, fv_q} + (CW+1)'(LANES)) >= {1'b0, num_fv_q};
  assign last_layer = (layer_q == num_layer_q);

  // Lane read muxes: lanes past the end of the feature vector read as zero.
  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [CW:0] idx;
      assign idx         = {1'b0, fv_q} + (CW+1)'(g);
      assign lane_vld[g] = idx < {1'b0, num_fv_q};
      assign lane_data[g*FV_SIZE +: FV_SIZE] = lane_vld[g] ? wbuf_q[layer_q][idx[FW-1:0]] : '0;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: leave IDLE on a non-empty fire, return after the final chunk.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.fire && (bus.num_fv != '0)) state_d = ST_WORK;
      ST_WORK: if (!bus.stall && last_chunk && last_layer) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: fire acceptance, chunk emission and strobe generation.
  always_comb begin
    accept     = 1'b0;
    emit       = 1'b0;
    strobe_gen = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.fire && (bus.num_fv != '0)) begin
          accept         = 1'b1;
          strobe_gen.sos = 1'b1;
        end
      end
      ST_WORK: begin
        if (!bus.stall) begin
          emit = 1'b1;
          if (last_chunk) begin
            strobe_gen.change = 1'b1;
            strobe_gen.eos    = last_layer;
          end
        end
      end
      default: ;
    endcase
  end

  // Counter and latched-configuration next-state logic.
  always_comb begin
    fv_d        = fv_q;
    layer_d     = layer_q;
    num_fv_d    = num_fv_q;
    num_layer_d = num_layer_q;
    if (accept) begin
      fv_d        = '0;
      layer_d     = '0;
      num_fv_d    = fire_fv;
      num_layer_d = fire_layer;
    end else if (emit) begin
      if (last_chunk) begin
        fv_d    = '0;
        layer_d = last_layer ? '0 : layer_q + 1'b1;
      end else begin
        fv_d = fv_q + CW'(LANES);
      end
    end
  end

  // Counter and configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fv_q        <= '0;
      layer_q     <= '0;
      num_fv_q    <= '0;
      num_layer_q <= '0;
    end else begin
      fv_q        <= fv_d;
      layer_q     <= layer_d;
      num_fv_q    <= num_fv_d;
      num_layer_q <= num_layer_d;
    end
  end

  // Weight buffer write port; frozen while a stream is running, never reset.
  always_ff @(posedge clk) begin
    if ((state_q == ST_IDLE) && bus.wr_en) begin
      for (int l = 0; l < MAX_LAYERS; l++) begin
        for (int e = 0; e < MAX_FV; e++) begin
          if ((bus.wr_layer == LW'(l)) && (bus.wr_idx == FW'(e))) wbuf_q[l][e] <= bus.wr_data;
        end
      end
    end
  end

  // Output registers: one-cycle latency, zeroed whenever no chunk is emitted.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdata_q     <= '0;
      wvalid_q    <= '0;
      cur_fv_q    <= '0;
      cur_layer_q <= '0;
      rs_idle_q   <= 1'b0;
    end else begin
      rs_idle_q <= (state_q == ST_IDLE) && !accept;
      if (emit) begin
        wdata_q     <= lane_data;
        wvalid_q    <= lane_vld;
        cur_fv_q    <= fv_q;
        cur_layer_q <= layer_q;
      end else begin
        wdata_q     <= '0;
        wvalid_q    <= '0;
        cur_fv_q    <= '0;
        cur_layer_q <= '0;
      end
    end
  end

  sig_delay_pipe #(
    .WIDTH (BW),
    .DEPTH (BANK_DLY)
  ) u_bank_dly (
    .clk   (clk),
    .reset (reset),
    .d_i   (strobe_gen),
    .q_o   (strobe_out_vec)
  );

  assign strobe_out       = weight_bank_ctrl_t'(strobe_out_vec);
  assign bus.weight_data  = wdata_q;
  assign bus.weight_valid = wvalid_q;
  assign bus.cur_fv_num   = cur_fv_q;
  assign bus.cur_layer    = cur_layer_q;
  assign bus.bank_sos     = strobe_out.sos;
  assign bus.bank_change  = strobe_out.change;
  assign bus.bank_eos     = strobe_out.eos;
  assign bus.rs_idle      = rs_idle_q;

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Directed bench for weight_stream_ctrl; cycle 0 of each run is the fire cycle.
module tb_weight_stream_ctrl;

  localparam int LANES = 4, FV_SIZE = 16, MAX_FV = 16, MAX_LAYERS = 2, BANK_DLY = 3;
  localparam int NC = 24;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  weight_stream_ctrl_if #(.LANES(LANES), .FV_SIZE(FV_SIZE), .MAX_FV(MAX_FV),
                          .MAX_LAYERS(MAX_LAYERS)) bus ();

  weight_stream_ctrl #(.LANES(LANES), .FV_SIZE(FV_SIZE), .MAX_FV(MAX_FV),
                       .MAX_LAYERS(MAX_LAYERS), .BANK_DLY(BANK_DLY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] model [2][16];

  logic [3:0]  o_vld [NC];
  logic [63:0] o_data [NC];
  logic [4:0]  o_fv [NC];
  logic        o_ly [NC], o_sos [NC], o_chg [NC], o_eos [NC], o_idle [NC];

  logic [3:0]  e_vld [NC];
  int          e_fv [NC], e_ly [NC];
  logic        e_sos [NC], e_chg [NC], e_eos [NC], e_idle [NC];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int c);
    @(negedge clk);
    if (c < NC) begin
      o_vld[c]  = bus.weight_valid;
      o_data[c] = bus.weight_data;
      o_fv[c]   = bus.cur_fv_num;
      o_ly[c]   = bus.cur_layer;
      o_sos[c]  = bus.bank_sos;
      o_chg[c]  = bus.bank_change;
      o_eos[c]  = bus.bank_eos;
      o_idle[c] = bus.rs_idle;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.fire = 1'b0; bus.stall = 1'b0; bus.wr_en = 1'b0;
    bus.wr_layer = '0; bus.wr_idx = '0; bus.wr_data = '0;
    bus.num_fv = '0; bus.num_layer = '0;
    reset = 1'b0;
  endtask

  task automatic write_buf(input int l, input int e, input logic [15:0] v);
    bus.wr_en = 1'b1; bus.wr_layer = 1'(l); bus.wr_idx = 4'(e); bus.wr_data = v;
    model[l][e] = v;
    step(NC);
    bus.wr_en = 1'b0;
  endtask

  // One stream: fire at cycle 0 (and fire2), stall in [st_lo,st_hi], reset at rst_at,
  // a write to layer1[5] at wr_at.
  task automatic run(input int ncyc, input logic [4:0] nfv, input logic nly, input int st_lo,
                     input int st_hi, input int fire2, input int rst_at, input int wr_at);
    for (int c = 0; c < ncyc; c++) begin
      bus.fire      = (c == 0) || (c == fire2);
      bus.num_fv    = nfv;
      bus.num_layer = nly;
      bus.stall     = (c >= st_lo) && (c <= st_hi);
      reset         = (c == rst_at);
      bus.wr_en     = (c == wr_at);
      bus.wr_layer  = 1'b1; bus.wr_idx = 4'd5; bus.wr_data = 16'h1111;
      step(c);
    end
    drive_idle();
  endtask

  task automatic exp_clear();
    for (int c = 0; c < NC; c++) begin
      e_vld[c] = '0; e_fv[c] = 0; e_ly[c] = 0;
      e_sos[c] = 1'b0; e_chg[c] = 1'b0; e_eos[c] = 1'b0; e_idle[c] = 1'b1;
    end
  endtask

  task automatic exp_chunk(input int c, input logic [3:0] v, input int fv, input int ly);
    e_vld[c] = v; e_fv[c] = fv; e_ly[c] = ly;
  endtask

  task automatic exp_busy(input int lo, input int hi);
    for (int c = lo; c <= hi; c++) e_idle[c] = 1'b0;
  endtask

  task automatic verify(input string name, input int ncyc);
    logic [63:0] ed;
    for (int c = 0; c < ncyc; c++) begin
      ed = '0;
      for (int i = 0; i < LANES; i++)
        if (e_vld[c][i]) ed[i*16 +: 16] = model[e_ly[c]][e_fv[c] + i];
      check($sformatf("%s c%0d valid", name, c), 64'(o_vld[c]), 64'(e_vld[c]));
      check($sformatf("%s c%0d data", name, c), o_data[c], ed);
      if (e_vld[c] != '0) begin
        check($sformatf("%s c%0d cur_fv", name, c), 64'(o_fv[c]), 64'(e_fv[c]));
        check($sformatf("%s c%0d cur_layer", name, c), 64'(o_ly[c]), 64'(e_ly[c]));
      end
      check($sformatf("%s c%0d sos", name, c), 64'(o_sos[c]), 64'(e_sos[c]));
      check($sformatf("%s c%0d change", name, c), 64'(o_chg[c]), 64'(e_chg[c]));
      check($sformatf("%s c%0d eos", name, c), 64'(o_eos[c]), 64'(e_eos[c]));
      check($sformatf("%s c%0d rs_idle", name, c), 64'(o_idle[c]), 64'(e_idle[c]));
    end
  endtask

  task automatic exp_full_run();
    exp_clear();
    for (int k = 0; k < 8; k++) exp_chunk(2 + k, 4'hF, (k % 4) * 4, k / 4);
    e_sos[3] = 1'b1; e_chg[7] = 1'b1; e_chg[11] = 1'b1; e_eos[11] = 1'b1;
    exp_busy(1, 9);
  endtask

  task automatic exp_partial();
    exp_clear();
    exp_chunk(2, 4'hF, 0, 0); exp_chunk(3, 4'hF, 4, 0); exp_chunk(4, 4'h3, 8, 0);
    e_sos[3] = 1'b1; e_chg[6] = 1'b1; e_eos[6] = 1'b1;
    exp_busy(1, 4);
  endtask

  task automatic exp_two_layer8();
    exp_clear();
    exp_chunk(2, 4'hF, 0, 0); exp_chunk(3, 4'hF, 4, 0);
    exp_chunk(4, 4'hF, 0, 1); exp_chunk(5, 4'hF, 4, 1);
    e_sos[3] = 1'b1; e_chg[5] = 1'b1; e_chg[7] = 1'b1; e_eos[7] = 1'b1;
    exp_busy(1, 5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    step(0);
    step(1);
    check("reset valid", 64'(o_vld[0]), 64'h0);
    check("reset data", o_data[0], 64'h0);
    check("reset strobes", 64'({o_sos[0], o_chg[0], o_eos[0]}), 64'h0);
    check("reset rs_idle", 64'(o_idle[0]), 64'h0);
    check("idle after reset", 64'(o_idle[1]), 64'h1);

    for (int l = 0; l < 2; l++)
      for (int e = 0; e < 16; e++) write_buf(l, e, 16'(16'hA000 + l * 256 + e));
    step(NC);

    run(14, 5'd16, 1'b1, 99, 99, 99, 99, 99);
    exp_full_run();
    verify("full", 14);

    run(10, 5'd10, 1'b0, 99, 99, 99, 99, 99);
    exp_partial();
    verify("partial", 10);

    run(10, 5'd8, 1'b0, 2, 3, 99, 99, 99);
    exp_clear();
    exp_chunk(2, 4'hF, 0, 0); exp_chunk(5, 4'hF, 4, 0);
    e_sos[3] = 1'b1; e_chg[7] = 1'b1; e_eos[7] = 1'b1;
    exp_busy(1, 5);
    verify("stall", 10);

    write_buf(1, 5, 16'hABCD);
    run(10, 5'd8, 1'b1, 99, 99, 2, 99, 3);
    exp_two_layer8();
    verify("write", 10);
    check("write lane1", 64'(o_data[5][31:16]), 64'hABCD);

    run(10, 5'd8, 1'b1, 99, 99, 99, 99, 99);
    exp_two_layer8();
    verify("rerun", 10);
    check("rerun lane1 kept", 64'(o_data[5][31:16]), 64'hABCD);

    run(14, 5'd16, 1'b1, 99, 99, 99, 4, 99);
    exp_clear();
    exp_chunk(2, 4'hF, 0, 0); exp_chunk(3, 4'hF, 4, 0); exp_chunk(4, 4'hF, 8, 0);
    e_sos[3] = 1'b1;
    exp_busy(1, 5);
    verify("midreset", 14);

    run(14, 5'd16, 1'b1, 99, 99, 99, 99, 99);
    exp_full_run();
    verify("after reset", 14);

    run(6, 5'd0, 1'b0, 99, 99, 99, 99, 99);
    exp_clear();
    verify("fv0", 6);

    run(10, 5'd20, 1'b0, 99, 99, 99, 99, 99);
    exp_clear();
    for (int k = 0; k < 4; k++) exp_chunk(2 + k, 4'hF, k * 4, 0);
    e_sos[3] = 1'b1; e_chg[7] = 1'b1; e_eos[7] = 1'b1;
    exp_busy(1, 5);
    verify("clamp", 10);

    run(14, 5'd10, 1'b0, 99, 99, 4, 99, 99);
    exp_partial();
    exp_chunk(6, 4'hF, 0, 0); exp_chunk(7, 4'hF, 4, 0); exp_chunk(8, 4'h3, 8, 0);
    e_sos[7] = 1'b1; e_chg[10] = 1'b1; e_eos[10] = 1'b1;
    exp_busy(1, 8);
    verify("b2b", 14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
